// File: rtl/dram_1rw1r_pkg.sv
// Shared definitions for the distributed queue-storage RAM and the
// peripheral-interconnect queue that instantiates it.
//   clog2    : ceiling log2 of a positive count (clog2(1) = 0)
//   dram_aw  : address width for an SZ-entry RAM, never below one bit
//   pi_op_e  : queue operation encoding stored in the op array
package dram_1rw1r_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // A one-entry RAM still carries a one-bit address so that address 1
  // exists and can be recognised as out of range.
  function automatic int unsigned dram_aw(input int unsigned sz);
    return (sz <= 1) ? 1 : clog2(sz);
  endfunction

  localparam int unsigned DRAM_SZ_DEFAULT = 2;
  localparam int unsigned DRAM_DW_DEFAULT = 16;

  typedef enum logic [1:0] {
    NOOP = 2'b00,
    WROP = 2'b01,
    RDOP = 2'b10,
    RWOP = 2'b11
  } pi_op_e;

endpackage

// File: rtl/dram_1rw1r.sv
// Two-port distributed RAM used as per-master queue storage.
// Port 0 is a combinational read port; port 1 writes on the rising edge
// of clk1_i and also reads combinationally. Contents clear asynchronously
// while rst_n_i is low.
//
// Parameters:
//   SZ : number of entries (>= 1, any value)
//   DW : entry width in bits (>= 1)
//   AW : derived address width, max(1, clog2(SZ))
// Ports:
//   clk1_i  in  1  : write clock, rising edge
//   rst_n_i in  1  : asynchronous active-low clear
//   we1_i   in  1  : port-1 write enable
//   addr0_i in  AW : port-0 read address
//   addr1_i in  AW : port-1 read/write address
//   i1      in  DW : port-1 write data
//   o0      out DW : mem[addr0_i], zero when out of range
//   o1      out DW : mem[addr1_i], zero when out of range
// Build option:
//   DRAM_WRBYPASS_EN : write-first reads; an in-range port-1 write is
//                      forwarded to o1, and to o0 when the addresses match.
//                      Undefined gives read-before-write.
module dram_1rw1r
  import dram_1rw1r_pkg::*;
#(
  parameter int unsigned SZ = DRAM_SZ_DEFAULT,
  parameter int unsigned DW = DRAM_DW_DEFAULT,
  localparam int unsigned AW = dram_aw(SZ)
) (
  input  logic          clk1_i,
  input  logic          rst_n_i,
  input  logic          we1_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] i1,
  output logic [DW-1:0] o0,
  output logic [DW-1:0] o1
);

  logic [DW-1:0] mem [SZ];
  logic [DW-1:0] rd0;
  logic [DW-1:0] rd1;

  // Per-entry address match rather than direct indexing: addresses at or
  // beyond SZ match no entry, so writes there drop and reads return zero
  // without a separate range check or an out-of-bounds array index.
  always_ff @(posedge clk1_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned e = 0; e < SZ; e++) begin
        mem[e] <= '0;
      end
    end else if (we1_i) begin
      for (int unsigned e = 0; e < SZ; e++) begin
        if (addr1_i == AW'(e)) begin
          mem[e] <= i1;
        end
      end
    end
  end

  always_comb begin
    rd0 = '0;
    rd1 = '0;
    for (int unsigned e = 0; e < SZ; e++) begin
      if (addr0_i == AW'(e)) begin
        rd0 = mem[e];
      end
      if (addr1_i == AW'(e)) begin
        rd1 = mem[e];
      end
    end
  end

`ifdef DRAM_WRBYPASS_EN
  logic addr1_ok;
  logic byp1;
  logic byp0;

  assign addr1_ok = (32'(addr1_i) < SZ);
  // Bypass is suppressed under reset so the outputs stay at zero.
  assign byp1     = rst_n_i && we1_i && addr1_ok;
  assign byp0     = byp1 && (addr0_i == addr1_i);

  always_comb begin
    o0 = byp0 ? i1 : rd0;
    o1 = byp1 ? i1 : rd1;
  end
`else
  always_comb begin
    o0 = rd0;
    o1 = rd1;
  end
`endif

endmodule

// File: tb/tb_dram_1rw1r.sv
// Self-checking bench for dram_1rw1r. Three instances share one stimulus:
// SZ=4, SZ=3 (non-power-of-two) and SZ=1 (one address bit, fed the LSB).
// Expected reads come from a per-instance array model updated on each edge.
module tb_dram_1rw1r;

  localparam int unsigned NK = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [1:0]  a0;
  logic [1:0]  a1;
  logic [15:0] d;
  logic [15:0] o0s [NK];
  logic [15:0] o1s [NK];

  logic [15:0] mdl [NK][4];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  dram_1rw1r #(.SZ(4), .DW(16)) u_dut4 (
    .clk1_i(clk), .rst_n_i(rst_n), .we1_i(we), .addr0_i(a0), .addr1_i(a1),
    .i1(d), .o0(o0s[0]), .o1(o1s[0])
  );

  dram_1rw1r #(.SZ(3), .DW(16)) u_dut3 (
    .clk1_i(clk), .rst_n_i(rst_n), .we1_i(we), .addr0_i(a0), .addr1_i(a1),
    .i1(d), .o0(o0s[1]), .o1(o1s[1])
  );

  dram_1rw1r #(.SZ(1), .DW(16)) u_dut1 (
    .clk1_i(clk), .rst_n_i(rst_n), .we1_i(we), .addr0_i(a0[0:0]), .addr1_i(a1[0:0]),
    .i1(d), .o0(o0s[2]), .o1(o1s[2])
  );

  function automatic int unsigned sz_of(input int unsigned k);
    case (k)
      0:       return 4;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  // Address as seen by instance k (the SZ=1 instance only gets the LSB).
  function automatic int unsigned eff(input int unsigned k, input logic [1:0] a);
    return (k == 2) ? 32'(a[0]) : 32'(a);
  endfunction

  function automatic logic [15:0] exp_rd(input int unsigned k, input int unsigned port);
    int unsigned ra;
    int unsigned wa;
    ra = eff(k, (port == 1) ? a1 : a0);
    wa = eff(k, a1);
    if (!rst_n) return '0;
`ifdef DRAM_WRBYPASS_EN
    if (we && (wa < sz_of(k)) && ((port == 1) || (ra == wa))) return d;
`endif
    return (ra < sz_of(k)) ? mdl[k][ra] : 16'h0000;
  endfunction

  task automatic reset_model();
    for (int k = 0; k < NK; k++)
      for (int i = 0; i < 4; i++) mdl[k][i] = '0;
  endtask

  task automatic drive(input logic w, input logic [1:0] x0, input logic [1:0] x1,
                       input logic [15:0] v);
    @(negedge clk);
    we = w; a0 = x0; a1 = x1; d = v;
    #1;
  endtask

  task automatic clk_edge();
    int unsigned wa;
    @(posedge clk);
    if (rst_n && we) begin
      for (int k = 0; k < NK; k++) begin
        wa = eff(k, a1);
        if (wa < sz_of(k)) mdl[k][wa] = d;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset_model();
    // Writes attempted across edges while reset is held must be ignored.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 2'(i), 16'hDEAD);
      clk_edge();
      for (int k = 0; k < NK; k++) begin
        n_tests++;
        if (o0s[k] !== 16'h0000 || o1s[k] !== 16'h0000) begin
          n_fail++;
          $display("FAIL reset_hold dut%0d addr=%0d o0=%h o1=%h exp=0000", k, i, o0s[k], o1s[k]);
        end
      end
    end
    // First edge after release honours the write.
    @(negedge clk);
    rst_n = 1'b1; we = 1'b1; a0 = 2'd0; a1 = 2'd0; d = 16'h5A5A;
    clk_edge();
    n_tests++;
    if (o0s[0] !== 16'h5A5A) begin
      n_fail++;
      $display("FAIL reset_release_write o0=%h exp=5a5a", o0s[0]);
    end
    drive(1'b1, 2'd0, 2'd0, 16'hAAAA); clk_edge();
    drive(1'b1, 2'd1, 2'd1, 16'hAAAA); clk_edge();
    drive(1'b0, 2'd0, 2'd1, 16'h0000);
    n_tests++;
    if (o0s[0] !== 16'hAAAA || o1s[0] !== 16'hAAAA) begin
      n_fail++;
      $display("FAIL reset_prefill o0=%h o1=%h exp=aaaa", o0s[0], o1s[0]);
    end
    // Mid-cycle pulse with no clock edge.
    #2 rst_n = 1'b0;
    reset_model();
    #1;
    for (int k = 0; k < NK; k++) begin
      n_tests++;
      if (o0s[k] !== 16'h0000 || o1s[k] !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_async dut%0d o0=%h o1=%h exp=0000", k, o0s[k], o1s[k]);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'(i), 2'(i), 16'hFFFF);
      for (int k = 0; k < NK; k++) begin
        n_tests++;
        if (o0s[k] !== 16'h0000 || o1s[k] !== 16'h0000) begin
          n_fail++;
          $display("FAIL reset_cleared dut%0d addr=%0d o0=%h o1=%h exp=0000", k, i, o0s[k], o1s[k]);
        end
      end
    end
  endtask

  task automatic test_basic();
    drive(1'b1, 2'd0, 2'd2, 16'h1234); clk_edge();
    drive(1'b0, 2'd2, 2'd2, 16'h0000);
    n_tests++;
    if (o0s[0] !== 16'h1234 || o1s[0] !== 16'h1234) begin
      n_fail++;
      $display("FAIL basic_rw o0=%h o1=%h exp=1234", o0s[0], o1s[0]);
    end
    for (int k = 0; k < NK; k++) begin
      n_tests++;
      if (o0s[k] !== exp_rd(k, 0) || o1s[k] !== exp_rd(k, 1)) begin
        n_fail++;
        $display("FAIL basic_model dut%0d o0=%h/%h o1=%h/%h", k, o0s[k], exp_rd(k, 0), o1s[k], exp_rd(k, 1));
      end
    end
  endtask

  task automatic test_dual_port();
    drive(1'b1, 2'd0, 2'd0, 16'h00FF); clk_edge();
    drive(1'b1, 2'd0, 2'd3, 16'hFF00); clk_edge();
    drive(1'b0, 2'd3, 2'd0, 16'h0000);
    n_tests++;
    if (o0s[0] !== 16'hFF00 || o1s[0] !== 16'h00FF) begin
      n_fail++;
      $display("FAIL dual_port o0=%h exp=ff00 o1=%h exp=00ff", o0s[0], o1s[0]);
    end
    #1 a0 = 2'd0; a1 = 2'd3;
    #1;
    n_tests++;
    if (o0s[0] !== 16'h00FF || o1s[0] !== 16'hFF00) begin
      n_fail++;
      $display("FAIL dual_port_swap o0=%h exp=00ff o1=%h exp=ff00", o0s[0], o1s[0]);
    end
    for (int k = 0; k < NK; k++) begin
      n_tests++;
      if (o0s[k] !== exp_rd(k, 0) || o1s[k] !== exp_rd(k, 1)) begin
        n_fail++;
        $display("FAIL dual_port_model dut%0d o0=%h/%h o1=%h/%h", k, o0s[k], exp_rd(k, 0), o1s[k], exp_rd(k, 1));
      end
    end
  endtask

  task automatic test_write_cycle_read();
    logic [15:0] pre;
`ifdef DRAM_WRBYPASS_EN
    pre = 16'd9;
`else
    pre = 16'd5;
`endif
    drive(1'b1, 2'd1, 2'd1, 16'd5); clk_edge();
    drive(1'b1, 2'd1, 2'd1, 16'd9);
    n_tests++;
    if (o0s[0] !== pre) begin
      n_fail++;
      $display("FAIL wcycle_pre o0=%h exp=%h", o0s[0], pre);
    end
    clk_edge();
    n_tests++;
    if (o0s[0] !== 16'd9 || o1s[0] !== 16'd9) begin
      n_fail++;
      $display("FAIL wcycle_post o0=%h o1=%h exp=0009", o0s[0], o1s[0]);
    end
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 2'd0, 2'd0, 16'd11); clk_edge();
    drive(1'b1, 2'd0, 2'd1, 16'd22); clk_edge();
    drive(1'b1, 2'd0, 2'd2, 16'd33); clk_edge();
    drive(1'b1, 2'd0, 2'd3, 16'd7);  clk_edge();
    drive(1'b0, 2'd3, 2'd3, 16'd0);
    n_tests++;
    if (o0s[1] !== 16'h0000 || o1s[1] !== 16'h0000) begin
      n_fail++;
      $display("FAIL oob_sz3 o0=%h o1=%h exp=0000", o0s[1], o1s[1]);
    end
    // SZ=1: address 3 has LSB 1, out of range; entry 0 keeps 33.
    n_tests++;
    if (o0s[2] !== 16'h0000) begin
      n_fail++;
      $display("FAIL oob_sz1 o0=%h exp=0000", o0s[2]);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'(i), 2'(i), 16'd0);
      n_tests++;
      if (o0s[1] !== 16'(11 * (i + 1))) begin
        n_fail++;
        $display("FAIL oob_keep addr=%0d o0=%h exp=%h", i, o0s[1], 16'(11 * (i + 1)));
      end
    end
    drive(1'b0, 2'd0, 2'd0, 16'd0);
    n_tests++;
    if (o0s[2] !== 16'd33) begin
      n_fail++;
      $display("FAIL sz1_entry0 o0=%h exp=0021", o0s[2]);
    end
  endtask

  task automatic test_we_low();
    for (int n = 0; n < 10; n++) begin
      drive(1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 16'($urandom));
      clk_edge();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'(i), 2'(3 - i), 16'($urandom));
      for (int k = 0; k < NK; k++) begin
        n_tests++;
        if (o0s[k] !== exp_rd(k, 0) || o1s[k] !== exp_rd(k, 1)) begin
          n_fail++;
          $display("FAIL we_low dut%0d addr=%0d o0=%h/%h o1=%h/%h", k, i, o0s[k], exp_rd(k, 0), o1s[k], exp_rd(k, 1));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom), 2'($urandom), 2'($urandom), 16'($urandom));
      for (int k = 0; k < NK; k++) begin
        n_tests++;
        if (o0s[k] !== exp_rd(k, 0) || o1s[k] !== exp_rd(k, 1)) begin
          n_fail++;
          $display("FAIL rand_pre n=%0d dut%0d o0=%h/%h o1=%h/%h", n, k, o0s[k], exp_rd(k, 0), o1s[k], exp_rd(k, 1));
        end
      end
      clk_edge();
      for (int k = 0; k < NK; k++) begin
        n_tests++;
        if (o0s[k] !== exp_rd(k, 0) || o1s[k] !== exp_rd(k, 1)) begin
          n_fail++;
          $display("FAIL rand_post n=%0d dut%0d o0=%h/%h o1=%h/%h", n, k, o0s[k], exp_rd(k, 0), o1s[k], exp_rd(k, 1));
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b1; we = 1'b0; a0 = '0; a1 = '0; d = '0;
    #1 rst_n = 1'b0;
    test_reset();
    test_basic();
    test_dual_port();
    test_write_cycle_read();
    test_out_of_range();
    test_we_low();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
